// File: rtl/pi_pipeline_mc.sv
// rtl/pi_pipeline_mc.sv - multi-channel time-multiplexed PI pipeline with anti-windup (optional PI_DEADBAND_EN)
module pi_pipeline_mc #(
    parameter int INPUT_WIDTH   = 18,
    parameter int OUTPUT_WIDTH  = 32,
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 2,
    parameter logic signed [63:0] PI_SATURATION_LOWER_BOUND = -64'sh80000,
    parameter logic signed [63:0] PI_SATURATION_UPPER_BOUND = 64'sh7FFFF,
    parameter logic signed [63:0] INTEGRAL_LOWER_BOUND      = -64'sh80000,
    parameter logic signed [63:0] INTEGRAL_UPPER_BOUND      = 64'sh7FFFF
) (
    input  logic                     clk,
    input  logic                     rst_L,
    input  logic                     in_valid,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    input  logic [INPUT_WIDTH-1:0]   setpoint,
    input  logic [INPUT_WIDTH-1:0]   actual,
    input  logic [OUTPUT_WIDTH-1:0]  kp,
    input  logic [OUTPUT_WIDTH-1:0]  ki,
    input  logic                     integral_clear,
`ifdef PI_DEADBAND_EN
    input  logic [OUTPUT_WIDTH-1:0]  deadband,
`endif
    output logic                     out_valid,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic [OUTPUT_WIDTH-1:0]  pi_result,
    output logic [OUTPUT_WIDTH-1:0]  out_integral,
    output logic                     out_saturated,
    output logic                     out_integral_saturated
);
    localparam int OW = OUTPUT_WIDTH;
    localparam int PW = 2 * OW;
    localparam int SW = PW + 1;
    localparam int IC = (OW + 1 > 64) ? OW + 1 : 64;
    localparam int PC = (SW > 64) ? SW : 64;
    localparam logic [CHANNEL_WIDTH:0] NUM_CH = (CHANNEL_WIDTH + 1)'(NUM_CHANNELS);

    logic                       v0_q, v1_q, v2_q, v3_q, v4_q, v5_q;
    logic [CHANNEL_WIDTH-1:0]   ch0_q, ch1_q, ch2_q, ch3_q, ch4_q, ch5_q;
    logic signed [INPUT_WIDTH-1:0] sp0_q, act0_q;
    logic signed [OW-1:0]       kp0_q, ki0_q, kp1_q, ki1_q, kp2_q, ki2_q;
    logic signed [OW-1:0]       err1_q, err2_q;
    logic signed [OW-1:0]       integ2_q, integ3_q, integ4_q, integ5_q;
    logic                       isat2_q, isat3_q, isat4_q, isat5_q;
    logic signed [PW-1:0]       pi3_q, pp3_q, pi4_q, pp4_q;
    logic signed [SW-1:0]       sum5_q;
    logic signed [OW-1:0]       integ_q [NUM_CHANNELS];

    logic                       out_valid_q, out_saturated_q, out_integral_saturated_q;
    logic [CHANNEL_WIDTH-1:0]   out_channel_q;
    logic [OW-1:0]              pi_result_q, out_integral_q;

    logic                       accept;
    logic signed [OW-1:0]       act_ext, sp_ext, err_raw, err1_d;
    logic signed [OW-1:0]       iprior, integ2_d;
    logic signed [OW:0]         isum;
    logic                       isat2_d;
    logic signed [PW-1:0]       integ_x, ki_x, err_x, kp_x;
    logic signed [PC-1:0]       sum_x;
    logic [OW-1:0]              pi_d;
    logic                       sat_d;
`ifdef PI_DEADBAND_EN
    logic [OW-1:0]              db0_q;
    logic signed [OW-1:0]       err_mag;
`endif

    assign accept = in_valid && ({1'b0, in_channel} < NUM_CH);

    always_comb begin
        act_ext = {{(OW - INPUT_WIDTH){act0_q[INPUT_WIDTH-1]}}, act0_q};
        sp_ext  = {{(OW - INPUT_WIDTH){sp0_q[INPUT_WIDTH-1]}}, sp0_q};
        err_raw = act_ext - sp_ext;
`ifdef PI_DEADBAND_EN
        err_mag = err_raw[OW-1] ? -err_raw : err_raw;
        err1_d  = ($unsigned(err_mag) <= db0_q) ? '0 : err_raw;
`else
        err1_d  = err_raw;
`endif
    end

    // A coinciding clear makes this update start from zero instead of the stored value.
    always_comb begin
        iprior   = integral_clear ? '0 : integ_q[ch1_q];
        isum     = {iprior[OW-1], iprior} + {err1_q[OW-1], err1_q};
        integ2_d = isum[OW-1:0];
        isat2_d  = 1'b0;
        if (IC'(isum) > IC'(INTEGRAL_UPPER_BOUND)) begin
            integ2_d = INTEGRAL_UPPER_BOUND[OW-1:0];
            isat2_d  = 1'b1;
        end else if (IC'(isum) < IC'(INTEGRAL_LOWER_BOUND)) begin
            integ2_d = INTEGRAL_LOWER_BOUND[OW-1:0];
            isat2_d  = 1'b1;
        end
    end

    always_comb begin
        integ_x = PW'(integ2_q);
        ki_x    = PW'(ki2_q);
        err_x   = PW'(err2_q);
        kp_x    = PW'(kp2_q);
        sum_x   = PC'(sum5_q);
        pi_d    = sum5_q[OW-1:0];
        sat_d   = 1'b0;
        if (sum_x > PC'(PI_SATURATION_UPPER_BOUND)) begin
            pi_d  = PI_SATURATION_UPPER_BOUND[OW-1:0];
            sat_d = 1'b1;
        end else if (sum_x < PC'(PI_SATURATION_LOWER_BOUND)) begin
            pi_d  = PI_SATURATION_LOWER_BOUND[OW-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ch0_q <= in_channel;
        sp0_q <= setpoint;
        act0_q <= actual;
        kp0_q <= kp;
        ki0_q <= ki;
`ifdef PI_DEADBAND_EN
        db0_q <= deadband;
`endif
        ch1_q <= ch0_q;  err1_q <= err1_d;   kp1_q <= kp0_q;  ki1_q <= ki0_q;
        ch2_q <= ch1_q;  err2_q <= err1_q;   kp2_q <= kp1_q;  ki2_q <= ki1_q;
        integ2_q <= integ2_d;  isat2_q <= isat2_d;
        ch3_q <= ch2_q;  integ3_q <= integ2_q;  isat3_q <= isat2_q;
        pi3_q <= integ_x * ki_x;
        pp3_q <= err_x * kp_x;
        ch4_q <= ch3_q;  integ4_q <= integ3_q;  isat4_q <= isat3_q;
        pi4_q <= pi3_q;  pp4_q <= pp3_q;
        ch5_q <= ch4_q;  integ5_q <= integ4_q;  isat5_q <= isat4_q;
        sum5_q <= SW'(pi4_q) + SW'(pp4_q);
        if (!rst_L) begin
            {v0_q, v1_q, v2_q, v3_q, v4_q, v5_q} <= '0;
        end else begin
            {v0_q, v1_q, v2_q, v3_q, v4_q, v5_q} <= {accept, v0_q, v1_q, v2_q, v3_q, v4_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            for (int i = 0; i < NUM_CHANNELS; i++) integ_q[i] <= '0;
        end else begin
            if (integral_clear) begin
                for (int i = 0; i < NUM_CHANNELS; i++) integ_q[i] <= '0;
            end
            if (v1_q) integ_q[ch1_q] <= integ2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            out_valid_q              <= 1'b0;
            out_channel_q            <= '0;
            pi_result_q              <= '0;
            out_integral_q           <= '0;
            out_saturated_q          <= 1'b0;
            out_integral_saturated_q <= 1'b0;
        end else begin
            out_valid_q <= v5_q;
            if (v5_q) begin
                out_channel_q            <= ch5_q;
                pi_result_q              <= pi_d;
                out_integral_q           <= integ5_q;
                out_saturated_q          <= sat_d;
                out_integral_saturated_q <= isat5_q;
            end
        end
    end

    assign out_valid              = out_valid_q;
    assign out_channel            = out_channel_q;
    assign pi_result              = pi_result_q;
    assign out_integral           = out_integral_q;
    assign out_saturated          = out_saturated_q;
    assign out_integral_saturated = out_integral_saturated_q;
endmodule

// File: tb/tb_pi_pipeline_mc.sv
// tb/tb_pi_pipeline_mc.sv - table-driven and directed checks for pi_pipeline_mc
module tb_pi_pipeline_mc;
    logic        clk = 1'b0;
    logic        rst_L, in_valid, integral_clear;
    logic [1:0]  in_channel;
    logic [17:0] setpoint, actual;
    logic [31:0] kp, ki;
`ifdef PI_DEADBAND_EN
    logic [31:0] deadband = '0;
`endif
    logic        out_valid, out_saturated, out_integral_saturated;
    logic [1:0]  out_channel;
    logic [31:0] pi_result, out_integral;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pi_pipeline_mc #(.NUM_CHANNELS(3)) dut (
        .clk(clk), .rst_L(rst_L), .in_valid(in_valid), .in_channel(in_channel),
        .setpoint(setpoint), .actual(actual), .kp(kp), .ki(ki),
        .integral_clear(integral_clear),
`ifdef PI_DEADBAND_EN
        .deadband(deadband),
`endif
        .out_valid(out_valid), .out_channel(out_channel), .pi_result(pi_result),
        .out_integral(out_integral), .out_saturated(out_saturated),
        .out_integral_saturated(out_integral_saturated)
    );

    typedef struct {
        logic v; logic [1:0] ch; int sp; int act; int kp; int ki; logic clr;
        logic ev; logic [31:0] epi; logic [31:0] eint; logic es; logic eis;
    } vec_t;
    localparam int NV = 21;
    vec_t tbl [NV];
    int nv = 0;

    task automatic add(input logic v, input logic [1:0] ch, input int sp, input int act,
                       input int kpv, input int kiv, input logic clr, input logic ev,
                       input logic [31:0] epi, input logic [31:0] eint, input logic es, input logic eis);
        tbl[nv] = '{v, ch, sp, act, kpv, kiv, clr, ev, epi, eint, es, eis};
        nv++;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input int sp, input int act,
                         input int kpv, input int kiv, input logic clr);
        in_valid = v; in_channel = ch; setpoint = 18'(sp); actual = 18'(act);
        kp = 32'(kpv); ki = 32'(kiv); integral_clear = clr;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic [1:0] ch, input logic [31:0] epi,
                              input logic [31:0] eint);
        int n = 0;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s: got no out_valid expected out_valid within 12 cycles", nm);
        end else begin
            chk({nm, "_ch"}, out_channel, ch);
            chk({nm, "_pi"}, pi_result, epi);
            chk({nm, "_int"}, out_integral, eint);
            chk({nm, "_flags"}, {out_saturated, out_integral_saturated}, 2'b00);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_L = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_channel, 0);
        chk("rst_pi", pi_result, 0);
        chk("rst_int", out_integral, 0);
        chk("rst_flags", {out_saturated, out_integral_saturated}, 0);

        add(1, 0, 100, 110, 2, 1, 0,  1, 30, 10, 0, 0);
        add(1, 1, 0, 5, 0, 1, 0,      1, 5, 5, 0, 0);
        add(1, 1, 0, 5, 0, 1, 0,      1, 10, 10, 0, 0);
        add(1, 1, 0, 5, 0, 1, 0,      1, 15, 15, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,      0, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 1, 0,      1, 3, 3, 0, 0);
        add(1, 2, 4, 0, 0, 1, 0,      1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0);
        add(1, 0, 0, 3, 0, 1, 0,      1, 6, 6, 0, 0);
        add(1, 2, 4, 0, 0, 1, 0,      1, 32'hFFFFFFF8, 32'hFFFFFFF8, 0, 0);
        add(1, 3, 0, 1, 0, 1, 0,      0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0,      1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,      0, 0, 0, 0, 0);
        add(1, 0, -131072, 131071, 0, 1, 0, 1, 32'h3FFFF, 32'h3FFFF, 0, 0);
        add(1, 0, -131072, 131071, 0, 1, 0, 1, 32'h7FFFE, 32'h7FFFE, 0, 0);
        add(1, 0, -131072, 131071, 0, 1, 0, 1, 32'h7FFFF, 32'h7FFFF, 0, 1);
        add(1, 1, -131072, 131071, 65536, 0, 0, 1, 32'h7FFFF, 32'h3FFFF, 1, 0);
        add(1, 2, 131071, -131072, 65536, 0, 0, 1, 32'hFFF80000, 32'hFFFC0001, 1, 0);

        for (int t = 0; t < nv + 7; t++) begin
            @(negedge clk);
            if (t >= 7) begin
                chk($sformatf("v%0d_valid", t - 7), out_valid, tbl[t-7].ev);
                if (tbl[t-7].ev) begin
                    chk($sformatf("v%0d_ch", t - 7), out_channel, tbl[t-7].ch);
                    chk($sformatf("v%0d_pi", t - 7), pi_result, tbl[t-7].epi);
                    chk($sformatf("v%0d_int", t - 7), out_integral, tbl[t-7].eint);
                    chk($sformatf("v%0d_sat", t - 7), out_saturated, tbl[t-7].es);
                    chk($sformatf("v%0d_isat", t - 7), out_integral_saturated, tbl[t-7].eis);
                end
            end
            if (t < nv) drive(tbl[t].v, tbl[t].ch, tbl[t].sp, tbl[t].act, tbl[t].kp, tbl[t].ki, tbl[t].clr);
            else drive(0, 0, 0, 0, 0, 0, 0);
        end

        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(1, 0, 0, 50, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("build50", 0, 50, 50);

        drive(1, 0, 0, 7, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(1, 0, 0, 1, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("clr_valid", out_valid, 1);
        chk("clr_int", out_integral, 7);
        chk("clr_pi", pi_result, 7);
        repeat (3) @(negedge clk);
        chk("after_clr_valid", out_valid, 1);
        chk("after_clr_int", out_integral, 8);
        chk("after_clr_pi", pi_result, 8);

        drive(1, 0, 0, 5, 0, 1, 0);
        repeat (3) @(negedge clk);
        rst_L = 1'b0;
        drive(1, 0, 0, 9, 0, 1, 0);
        @(negedge clk);
        rst_L = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_int", out_integral, 0);
        chk("midrst_pi", pi_result, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_flush", seen, 0);

        for (int c = 0; c < 3; c++) begin
            drive(1, 2'(c), 0, 0, 0, 1, 0);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            expect_out($sformatf("probe_ch%0d", c), 2'(c), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
